bg_scroll_ctl: RTL and testbench

- Frame-synchronous scroll controller for the tiled background drawer.
- Produces the vertical scroll offset that the drawer adds to vcount before forming its tile-ROM row address.
- Runs a game-phase state machine and ramps scroll speed over time.
- All visible changes are committed only at the start of vertical blanking, so the offset never changes mid-frame.

---
 rtl/bg_ctl_pkg.sv | 26 ++
 rtl/bg_scroll_ctl_if.sv | 29 ++
 rtl/bg_scroll_ctl_frame_tick_gen.sv | 23 ++
 rtl/bg_scroll_ctl.sv | 117 +++++++++++
 tb/tb_bg_scroll_ctl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bg_ctl_pkg.sv
// Shared definitions for the background controller and the player-physics block.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
// Contents: state encoding, default ramp/catchup parameters, step-size helper.
package bg_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int SPEED_MAX_DEF        = 4;
    localparam int FRAMES_PER_LEVEL_DEF = 600;
    localparam int CATCHUP_SPEED_DEF    = 6;

    // Rows advanced in one frame: the ramp level, raised to the catchup
    // floor while the player sits in the top zone.
    function automatic logic [2:0] step_rows(input logic [2:0] level,
                                             input logic       catchup,
                                             input logic [2:0] floor_spd);
        return (catchup && (floor_spd > level)) ? floor_spd : level;
    endfunction

endpackage

// File: rtl/bg_scroll_ctl_if.sv
// Bundle between the timing chain / game logic and the scroll controller.
// Latency: none (wires only).
// Backpressure: none; requests are single-cycle pulses latched by the slave.
// master: drives vblnk/requests/catchup, observes scroll state.
// slave : the controller; consumes requests, drives scroll state and frame_tick.
interface bg_scroll_ctl_if #(
    parameter int OFFSET_W = 11
);
    logic                vblnk_in;
    logic                start_in;
    logic                pause_in;
    logic                halt_in;
    logic                catchup_in;
    logic [OFFSET_W-1:0] scroll_offset;
    logic [2:0]          speed_level;
    logic [1:0]          state_out;
    logic [15:0]         total_rows;
    logic                frame_tick;

    modport master (
        output vblnk_in, start_in, pause_in, halt_in, catchup_in,
        input  scroll_offset, speed_level, state_out, total_rows, frame_tick
    );

    modport slave (
        input  vblnk_in, start_in, pause_in, halt_in, catchup_in,
        output scroll_offset, speed_level, state_out, total_rows, frame_tick
    );
endinterface

// File: rtl/bg_scroll_ctl_frame_tick_gen.sv
// Rising-edge detector for vertical blank, one register deep.
// Latency: pulse is high while vblnk_i is high and its registered copy is still low.
// Backpressure: none.
// Ports: pclk_i, rst_i (async, active-high), vblnk_i in; frame_tick_o out.
module frame_tick_gen (
    input  logic pclk_i,
    input  logic rst_i,
    input  logic vblnk_i,
    output logic frame_tick_o
);
    logic vblnk_q;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vblnk_i;
        end
    end

    // Masked by reset so the pulse reads 0 the moment reset asserts.
    assign frame_tick_o = vblnk_i & ~vblnk_q & ~rst_i;
endmodule

// File: rtl/bg_scroll_ctl.sv
// Frame-synchronous vertical scroll controller: game-phase FSM plus speed ramp.
// Latency: a frame tick on cycle N updates every output on cycle N+1.
// Backpressure: none; start/pause/halt pulses are held pending until the next tick.
// Ports: pclk_in, rst_in (async, active-high); bus (slave modport) carries
// vblnk/requests/catchup in and scroll_offset/speed_level/state/total_rows/frame_tick out.
module bg_scroll_ctl
    import bg_ctl_pkg::*;
#(
    parameter int OFFSET_W         = 11,
    parameter int SPEED_MAX        = SPEED_MAX_DEF,
    parameter int FRAMES_PER_LEVEL = FRAMES_PER_LEVEL_DEF,
    parameter int CATCHUP_SPEED    = CATCHUP_SPEED_DEF
) (
    input  logic            pclk_in,
    input  logic            rst_in,
    bg_scroll_ctl_if.slave  bus
);
    localparam int CNT_W = ($clog2(FRAMES_PER_LEVEL) > 10) ? $clog2(FRAMES_PER_LEVEL) : 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_LEVEL - 1);
    localparam logic [2:0]       LVL_MAX  = 3'(SPEED_MAX);
    localparam logic [2:0]       CATCH    = 3'(CATCHUP_SPEED);

    logic                tick;
    state_e              state_q;
    logic [OFFSET_W-1:0] offset_q;
    logic [2:0]          level_q;
    logic [15:0]         rows_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                start_pend_q, pause_pend_q, halt_pend_q;

    logic                start_req, pause_req, halt_req, step_en;
    logic [2:0]          step;
    logic [OFFSET_W-1:0] offset_d;
    logic [16:0]         rows_sum;
    logic [15:0]         rows_d;

    frame_tick_gen u_tick (
        .pclk_i       (pclk_in),
        .rst_i        (rst_in),
        .vblnk_i      (bus.vblnk_in),
        .frame_tick_o (tick)
    );

    always_comb begin
        // A pulse landing on the tick cycle itself counts for that tick.
        start_req = start_pend_q | bus.start_in;
        pause_req = pause_pend_q | bus.pause_in;
        halt_req  = halt_pend_q  | bus.halt_in;
        // Only the top pending request takes the tick, even when the state
        // ignores it. A start in RUN is ignored and so does not block the step;
        // a pause below it is discarded.
        step_en   = (state_q == ST_RUN) & ~halt_req & (start_req | ~pause_req);
        step      = step_rows(level_q, bus.catchup_in, CATCH);
        offset_d  = offset_q + OFFSET_W'(step);
        rows_sum  = {1'b0, rows_q} + 17'(step);
        rows_d    = rows_sum[16] ? 16'hFFFF : rows_sum[15:0];
    end

    always_ff @(posedge pclk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            offset_q     <= '0;
            level_q      <= '0;
            rows_q       <= '0;
            cnt_q        <= '0;
            start_pend_q <= 1'b0;
            pause_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else if (tick) begin
            start_pend_q <= 1'b0;
            pause_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
            if (halt_req) begin
                if (state_q != ST_IDLE) begin
                    state_q <= ST_HALT;
                end
            end else if (start_req) begin
                if ((state_q == ST_IDLE) || (state_q == ST_HALT)) begin
                    state_q  <= ST_RUN;
                    offset_q <= '0;
                    rows_q   <= '0;
                    level_q  <= 3'd1;
                    cnt_q    <= '0;
                end
            end else if (pause_req) begin
                if (state_q == ST_RUN) begin
                    state_q <= ST_PAUSE;
                end else if (state_q == ST_PAUSE) begin
                    state_q <= ST_RUN;
                end
            end
            // Step uses the current level; a ramp increment shows next tick.
            if (step_en) begin
                offset_q <= offset_d;
                rows_q   <= rows_d;
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    if (level_q < LVL_MAX) begin
                        level_q <= level_q + 3'd1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else begin
            start_pend_q <= start_pend_q | bus.start_in;
            pause_pend_q <= pause_pend_q | bus.pause_in;
            halt_pend_q  <= halt_pend_q  | bus.halt_in;
        end
    end

    assign bus.scroll_offset = offset_q;
    assign bus.speed_level   = level_q;
    assign bus.state_out     = state_q;
    assign bus.total_rows    = rows_q;
    assign bus.frame_tick    = tick;
endmodule

// File: tb/tb_bg_scroll_ctl.sv
module tb_bg_scroll_ctl;
    localparam int OW   = 11;
    localparam int SMAX = 2;
    localparam int FPL  = 4;
    localparam int CSPD = 6;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    bg_scroll_ctl_if #(.OFFSET_W(OW)) bus ();

    bg_scroll_ctl #(
        .OFFSET_W        (OW),
        .SPEED_MAX       (SMAX),
        .FRAMES_PER_LEVEL(FPL),
        .CATCHUP_SPEED   (CSPD)
    ) dut (
        .pclk_in (pclk),
        .rst_in  (rst),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: state 0..3, offset/rows as integers, level derived
    // from the number of steps taken since the last start.
    int m_state, m_off, m_lvl, m_rows, m_steps;
    bit m_ps, m_pp, m_ph;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int lvl_of(input int steps);
        int l;
        l = 1 + steps / FPL;
        return (l > SMAX) ? SMAX : l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_off = 0; m_lvl = 0; m_rows = 0; m_steps = 0;
        m_ps = 0; m_pp = 0; m_ph = 0;
    endtask

    task automatic model_step(input bit cu);
        int st;
        st = (cu && CSPD > m_lvl) ? CSPD : m_lvl;
        m_off  = (m_off + st) % (1 << OW);
        m_rows = (m_rows + st > 65535) ? 65535 : m_rows + st;
        m_steps++;
        m_lvl = lvl_of(m_steps);
    endtask

    task automatic model_tick(input bit s, input bit p, input bit h, input bit cu);
        bit rs, rp, rh;
        rs = m_ps | s; rp = m_pp | p; rh = m_ph | h;
        m_ps = 0; m_pp = 0; m_ph = 0;
        if (rh) begin
            if (m_state != 0) m_state = 3;
        end else if (rs) begin
            if (m_state == 0 || m_state == 3) begin
                m_state = 1; m_off = 0; m_rows = 0; m_steps = 0; m_lvl = 1;
            end else if (m_state == 1) begin
                model_step(cu);
            end
        end else if (rp) begin
            if (m_state == 1) m_state = 2;
            else if (m_state == 2) m_state = 1;
        end else if (m_state == 1) begin
            model_step(cu);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(bus.state_out), 32'(m_state));
        chk({tag, ".offset"}, 32'(bus.scroll_offset), 32'(m_off));
        chk({tag, ".level"}, 32'(bus.speed_level), 32'(m_lvl));
        chk({tag, ".rows"}, 32'(bus.total_rows), 32'(m_rows));
    endtask

    // One frame-start: raise vblnk (optionally with same-cycle requests),
    // take the tick edge, then drop vblnk and check the committed outputs.
    task automatic tick(input bit s, input bit p, input bit h, input bit cu, input string tag);
        @(negedge pclk);
        bus.vblnk_in = 1'b1; bus.start_in = s; bus.pause_in = p; bus.halt_in = h;
        bus.catchup_in = cu;
        #1 chk({tag, ".ftick_hi"}, 32'(bus.frame_tick), 32'd1);
        @(posedge pclk);
        model_tick(s, p, h, cu);
        @(negedge pclk);
        bus.vblnk_in = 1'b0; bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.halt_in = 1'b0;
        chk({tag, ".ftick_lo"}, 32'(bus.frame_tick), 32'd0);
        check_all(tag);
    endtask

    // Mid-frame request pulse: must be latched but change nothing visible.
    task automatic req_pulse(input bit s, input bit p, input bit h, input string tag);
        @(negedge pclk);
        bus.start_in = s; bus.pause_in = p; bus.halt_in = h;
        @(negedge pclk);
        bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.halt_in = 1'b0;
        m_ps |= s; m_pp |= p; m_ph |= h;
        check_all(tag);
    endtask

    initial begin
        bus.vblnk_in = 1'b0; bus.start_in = 1'b0; bus.pause_in = 1'b0;
        bus.halt_in = 1'b0; bus.catchup_in = 1'b0;
        model_reset();
        #1 check_all("reset");
        chk("reset.ftick", 32'(bus.frame_tick), 32'd0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;

        // Idle: ticks with nothing pending keep IDLE; halt in IDLE is ignored.
        tick(0, 0, 0, 0, "idle");
        req_pulse(0, 0, 1, "idle_halt_req");
        tick(0, 0, 0, 0, "idle_halt");

        // Start mid-frame, then three ticks: offsets 0,1,2, rows 2.
        req_pulse(1, 0, 0, "start_req");
        tick(0, 0, 0, 0, "start_t1");
        tick(0, 0, 0, 0, "start_t2");
        tick(0, 0, 0, 0, "start_t3");
        chk("start.rows2", 32'(bus.total_rows), 32'd2);

        // Ramp: level climbs to SPEED_MAX and holds.
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0, "ramp");
            chk("ramp.max", 32'(bus.speed_level <= 3'(SMAX)), 32'd1);
        end

        // Restart, take two steps, pause for three ticks, resume.
        req_pulse(0, 0, 1, "halt_req");
        tick(0, 0, 0, 0, "halt");
        tick(1, 0, 0, 0, "restart_same_cycle");
        tick(0, 0, 0, 0, "pre_pause1");
        tick(0, 0, 0, 0, "pre_pause2");
        req_pulse(0, 1, 0, "pause_req");
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, "paused");
        req_pulse(0, 1, 0, "resume_req");
        tick(0, 0, 0, 0, "resume_tick");
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, "after_resume");

        // Halt and start in the same frame: halt wins, start is dropped.
        req_pulse(1, 0, 1, "halt_start_req");
        tick(0, 0, 0, 0, "halt_wins");
        tick(0, 0, 0, 0, "halt_frozen");
        req_pulse(1, 0, 0, "restart_req");
        tick(0, 0, 0, 0, "restart");

        // Start while running is ignored and the step still happens;
        // a pause pending underneath it is discarded.
        tick(0, 0, 0, 0, "run_a");
        req_pulse(1, 1, 0, "start_pause_req");
        tick(0, 0, 0, 0, "start_in_run");

        // Reset mid-frame while running, with a start pending.
        tick(0, 0, 0, 1, "pre_reset");
        req_pulse(1, 0, 0, "pend_before_reset");
        @(negedge pclk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("mid_reset");
        chk("mid_reset.ftick", 32'(bus.frame_tick), 32'd0);
        @(negedge pclk);
        rst = 1'b0;
        tick(0, 0, 0, 0, "post_reset");

        // Catchup: offset wraps many times, total_rows saturates.
        tick(1, 0, 0, 1, "sat_start");
        for (int i = 0; i < 11000; i++) tick(0, 0, 0, 1, "sat");
        chk("sat.rows_max", 32'(bus.total_rows), 32'hFFFF);

        // Randomised frames with mixed requests and catchup.
        for (int f = 0; f < 600; f++) begin
            int r;
            bit s, p, h;
            r = $urandom_range(0, 99);
            if (r < 8)       req_pulse(1, 0, 0, "rnd_mid");
            else if (r < 16) req_pulse(0, 1, 0, "rnd_mid");
            else if (r < 19) req_pulse(0, 0, 1, "rnd_mid");
            else if (r < 21) req_pulse(1, 1, 1, "rnd_mid");
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            r = $urandom_range(0, 99);
            s = (r < 6);
            p = (r >= 6 && r < 10);
            h = (r >= 10 && r < 12);
            tick(s, p, h, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
